// File: rtl/speller_pkg.sv
// Shared word vocabulary for the number speller: word IDs, word lengths and
// a character lookup over left-aligned ASCII word images.
package speller_pkg;

  localparam int MAX_WORDS    = 5;
  localparam int MAX_WORD_LEN = 9;
  localparam int IDX_W        = $clog2(MAX_WORD_LEN);

  typedef enum logic [4:0] {
    W_NONE = 5'd0,
    W_ONE, W_TWO, W_THREE, W_FOUR, W_FIVE, W_SIX, W_SEVEN, W_EIGHT, W_NINE,
    W_TEN, W_ELEVEN, W_TWELVE, W_THIRTEEN, W_FOURTEEN, W_FIFTEEN, W_SIXTEEN,
    W_SEVENTEEN, W_EIGHTEEN, W_NINETEEN,
    W_TWENTY, W_THIRTY, W_FORTY, W_FIFTY, W_SIXTY, W_SEVENTY, W_EIGHTY, W_NINETY,
    W_HUNDRED, W_AND, W_THOUSAND
  } word_id_t;

  localparam logic [3:0] WORD_LEN [32] = '{
    4'd0,
    4'd3, 4'd3, 4'd5, 4'd4, 4'd4, 4'd3, 4'd5, 4'd5, 4'd4,
    4'd3, 4'd6, 4'd6, 4'd8, 4'd8, 4'd7, 4'd7, 4'd9, 4'd8, 4'd8,
    4'd6, 4'd6, 4'd5, 4'd5, 4'd5, 4'd7, 4'd6, 4'd6,
    4'd7, 4'd3, 4'd8,
    4'd0
  };

  // Word text packed first-letter-in-MSB, zero padded on the right.
  function automatic logic [71:0] word_text(input word_id_t id);
    case (id)
      W_ONE:       return {"one", 48'h0};
      W_TWO:       return {"two", 48'h0};
      W_THREE:     return {"three", 32'h0};
      W_FOUR:      return {"four", 40'h0};
      W_FIVE:      return {"five", 40'h0};
      W_SIX:       return {"six", 48'h0};
      W_SEVEN:     return {"seven", 32'h0};
      W_EIGHT:     return {"eight", 32'h0};
      W_NINE:      return {"nine", 40'h0};
      W_TEN:       return {"ten", 48'h0};
      W_ELEVEN:    return {"eleven", 24'h0};
      W_TWELVE:    return {"twelve", 24'h0};
      W_THIRTEEN:  return {"thirteen", 8'h0};
      W_FOURTEEN:  return {"fourteen", 8'h0};
      W_FIFTEEN:   return {"fifteen", 16'h0};
      W_SIXTEEN:   return {"sixteen", 16'h0};
      W_SEVENTEEN: return "seventeen";
      W_EIGHTEEN:  return {"eighteen", 8'h0};
      W_NINETEEN:  return {"nineteen", 8'h0};
      W_TWENTY:    return {"twenty", 24'h0};
      W_THIRTY:    return {"thirty", 24'h0};
      W_FORTY:     return {"forty", 32'h0};
      W_FIFTY:     return {"fifty", 32'h0};
      W_SIXTY:     return {"sixty", 32'h0};
      W_SEVENTY:   return {"seventy", 16'h0};
      W_EIGHTY:    return {"eighty", 24'h0};
      W_NINETY:    return {"ninety", 24'h0};
      W_HUNDRED:   return {"hundred", 16'h0};
      W_AND:       return {"and", 48'h0};
      W_THOUSAND:  return {"thousand", 8'h0};
      default:     return 72'h0;
    endcase
  endfunction

  function automatic logic [7:0] word_char(input word_id_t id, input logic [IDX_W-1:0] index);
    logic [71:0] shifted;
    shifted = word_text(id) << {index, 3'b000};
    return shifted[71:64];
  endfunction

endpackage

// File: rtl/number_speller_word_rom.sv
// Combinational word lookup: (word, character index) -> ASCII character and
// an end-of-word flag.
module word_rom
  import speller_pkg::*;
(
  input  logic [4:0]       word,
  input  logic [IDX_W-1:0] index,
  output logic [7:0]       ch,
  output logic             last
);

  assign ch   = word_char(word_id_t'(word), index);
  assign last = (WORD_LEN[word] != 4'd0) && (index == WORD_LEN[word] - 4'd1);

endmodule

// File: rtl/number_speller.sv
// Spells a number 1..1000 in British English as a stream of lowercase ASCII
// characters, one per char_valid/char_ready handshake.
module number_speller
  import speller_pkg::*;
#(
  parameter bit EMIT_SPACES = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        num_valid,
  output logic        num_ready,
  input  logic [9:0]  num_value,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_data,
  output logic        char_last,
  output logic        bad_num,
  output logic [15:0] letter_total
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;
  localparam logic [1:0] SPACE = 2'd3;

  logic [1:0]       state;
  logic [9:0]       value;
  word_id_t         words [MAX_WORDS];
  logic [2:0]       word_count;
  logic [2:0]       wi;
  logic [IDX_W-1:0] ci;
  logic [15:0]      total;
  logic             bad;

  logic [3:0] h, t, o;
  logic [6:0] rem;
  word_id_t   list [MAX_WORDS];
  logic [2:0] n;

  // Word list built in spoken order; n ends as the number of words.
  always_comb begin
    h   = 4'(value / 10'd100);
    rem = 7'(value % 10'd100);
    t   = 4'(rem / 7'd10);
    o   = 4'(rem % 7'd10);
    for (int i = 0; i < MAX_WORDS; i++) list[i] = W_NONE;
    n = 3'd0;
    if (value == 10'd1000) begin
      list[0] = W_ONE;
      list[1] = W_THOUSAND;
      n = 3'd2;
    end else begin
      if (h != 4'd0) begin
        list[n] = word_id_t'({1'b0, h});
        n = n + 3'd1;
        list[n] = W_HUNDRED;
        n = n + 3'd1;
        if (rem != 7'd0) begin
          list[n] = W_AND;
          n = n + 3'd1;
        end
      end
      if (t == 4'd1) begin
        list[n] = word_id_t'(5'(rem));
        n = n + 3'd1;
      end else if (t >= 4'd2) begin
        list[n] = word_id_t'(5'(t) + 5'd18);
        n = n + 3'd1;
      end
      if (o != 4'd0 && t != 4'd1) begin
        list[n] = word_id_t'({1'b0, o});
        n = n + 3'd1;
      end
    end
  end

  logic [7:0] rom_ch;
  logic       rom_last;
  logic       final_char;

  word_rom u_rom (
    .word  (words[wi]),
    .index (ci),
    .ch    (rom_ch),
    .last  (rom_last)
  );

  assign final_char = rom_last && (wi == word_count - 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      value      <= 10'd0;
      word_count <= 3'd0;
      wi         <= 3'd0;
      ci         <= '0;
      total      <= 16'd0;
      bad        <= 1'b0;
      for (int i = 0; i < MAX_WORDS; i++) words[i] <= W_NONE;
    end else begin
      bad <= 1'b0;
      case (state)
        IDLE: begin
          if (num_valid) begin
            value <= num_value;
            if (num_value == 10'd0 || num_value > 10'd1000) bad <= 1'b1;
            else state <= LOAD;
          end
        end
        LOAD: begin
          for (int i = 0; i < MAX_WORDS; i++) words[i] <= list[i];
          word_count <= n;
          wi         <= 3'd0;
          ci         <= '0;
          state      <= EMIT;
        end
        EMIT: begin
          if (char_ready) begin
            total <= total + 16'd1;
            if (final_char) begin
              state <= IDLE;
            end else if (rom_last) begin
              wi <= wi + 3'd1;
              ci <= '0;
              if (EMIT_SPACES) state <= SPACE;
            end else begin
              ci <= ci + 1'b1;
            end
          end
        end
        SPACE: begin
          if (char_ready) state <= EMIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign num_ready    = (state == IDLE);
  assign char_valid   = (state == EMIT) || (state == SPACE);
  assign char_data    = (state == EMIT) ? rom_ch : (state == SPACE) ? 8'h20 : 8'h00;
  assign char_last    = (state == EMIT) && final_char;
  assign bad_num      = bad;
  assign letter_total = total;

endmodule

// File: tb/tb_number_speller.sv
// Directed, table-driven bench for number_speller, with hand-written
// sequences for back-to-back numbers, spaces, mid-stream reset and a sweep.
module tb_number_speller;

  logic        clk = 1'b0;
  logic        reset;
  logic        num_valid, num_ready, char_valid, char_ready, char_last, bad_num;
  logic [9:0]  num_value;
  logic [7:0]  char_data;
  logic [15:0] letter_total;

  logic        s_num_valid, s_num_ready, s_char_valid, s_char_ready, s_char_last, s_bad_num;
  logic [9:0]  s_num_value;
  logic [7:0]  s_char_data;
  logic [15:0] s_letter_total;

  always #5 clk = ~clk;

  number_speller #(.EMIT_SPACES(1'b0)) dut (
    .clk(clk), .reset(reset),
    .num_valid(num_valid), .num_ready(num_ready), .num_value(num_value),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
    .char_last(char_last), .bad_num(bad_num), .letter_total(letter_total)
  );

  number_speller #(.EMIT_SPACES(1'b1)) dut_s (
    .clk(clk), .reset(reset),
    .num_valid(s_num_valid), .num_ready(s_num_ready), .num_value(s_num_value),
    .char_valid(s_char_valid), .char_ready(s_char_ready), .char_data(s_char_data),
    .char_last(s_char_last), .bad_num(s_bad_num), .letter_total(s_letter_total)
  );

  int total = 0;
  int bad = 0;
  int letters_seen = 0;
  int lasts_seen = 0;

  typedef struct {
    int    value;
    string text;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Waits (bounded) for num_ready, offers v for one cycle, then scrambles num_value.
  task automatic send_num(input int v, output int w);
    bit is_bad;
    is_bad = (v == 0) || (v > 1000);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!num_ready && w < 200);
    if (!num_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: num_ready got 0 expected 1 for value %0d", v);
    end
    num_valid = 1'b1;
    num_value = 10'(v);
    @(negedge clk);
    num_valid = 1'b0;
    num_value = 10'($urandom_range(0, 1023));
    check($sformatf("load_char_valid %0d", v), int'(char_valid), 0);
    check($sformatf("bad_num %0d", v), int'(bad_num), int'(is_bad));
    if (is_bad) check($sformatf("bad_ready %0d", v), int'(num_ready), 1);
  endtask

  task automatic collect(input string exp, input bit check_text, input bit rand_ready,
                         input int max_chars, output int nchars, output int lat);
    int         cyc;
    bit         done;
    bit         stalled;
    logic [7:0] hd;
    logic       hl;
    int         mism;
    cyc = 0; done = 0; stalled = 0; mism = 0; hd = 8'h0; hl = 1'b0;
    nchars = 0;
    lat = -1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("stall_valid", int'(char_valid), 1);
        check("stall_data", int'(char_data), int'(hd));
        check("stall_last", int'(char_last), int'(hl));
      end
      if (char_valid && lat < 0) lat = cyc;
      char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (char_valid && char_ready) begin
        if (check_text && (nchars >= exp.len() || char_data != exp.getc(nchars))) mism++;
        if (char_data != 8'h20) letters_seen++;
        if (char_last) begin
          lasts_seen++;
          done = 1;
        end
        nchars++;
        if (max_chars > 0 && nchars == max_chars) done = 1;
      end
      stalled = char_valid && !char_ready;
      hd = char_data;
      hl = char_last;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL collect_timeout: got %0d chars, no char_last within 400 cycles", nchars);
    end
    if (check_text) begin
      check({"text ", exp}, mism, 0);
      check({"length ", exp}, nchars, exp.len());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    w, n, lat, exp_total, idx, mism;
    string sp;

    vecs[0]  = '{342,  "threehundredandfortytwo"};
    vecs[1]  = '{0,    ""};
    vecs[2]  = '{1023, ""};
    vecs[3]  = '{100,  "onehundred"};
    vecs[4]  = '{13,   "thirteen"};
    vecs[5]  = '{999,  "ninehundredandninetynine"};
    vecs[6]  = '{20,   "twenty"};
    vecs[7]  = '{101,  "onehundredandone"};
    vecs[8]  = '{510,  "fivehundredandten"};
    vecs[9]  = '{1000, "onethousand"};
    vecs[10] = '{1001, ""};

    num_valid = 0; num_value = 0; char_ready = 0;
    s_num_valid = 0; s_num_value = 0; s_char_ready = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_num_ready", int'(num_ready), 1);
    check("rst_char_valid", int'(char_valid), 0);
    check("rst_char_data", int'(char_data), 0);
    check("rst_char_last", int'(char_last), 0);
    check("rst_bad_num", int'(bad_num), 0);
    check("rst_letter_total", int'(letter_total), 0);

    exp_total = 0;
    for (int i = 0; i < 11; i++) begin
      send_num(vecs[i].value, w);
      if (vecs[i].text.len() == 0) begin
        repeat (3) begin
          @(negedge clk);
          check("bad_no_valid", int'(char_valid), 0);
          check("bad_single_pulse", int'(bad_num), 0);
          check("bad_idle_ready", int'(num_ready), 1);
        end
      end else begin
        collect(vecs[i].text, 1'b1, 1'b0, 0, n, lat);
        check($sformatf("first_char_latency %0d", vecs[i].value), lat, 1);
        exp_total += vecs[i].text.len();
        @(negedge clk);
        check("ready_after_last", int'(num_ready), 1);
      end
      check($sformatf("letter_total after %0d", vecs[i].value), int'(letter_total), exp_total);
    end

    // 115 then 1000 back to back: num_ready must return one cycle after each last char.
    send_num(115, w);
    collect("onehundredandfifteen", 1'b1, 1'b0, 0, n, lat);
    check("b2b_ready_low_at_last", int'(num_ready), 0);
    send_num(1000, w);
    check("b2b_ready_rise_cycles", w, 1);
    collect("onethousand", 1'b1, 1'b0, 0, n, lat);
    @(negedge clk);
    check("b2b_ready_after_1000", int'(num_ready), 1);
    exp_total += 31;
    check("b2b_letter_total", int'(letter_total), exp_total);

    // Spaced variant: "twenty one", space excluded from the letter count.
    sp = "twenty one";
    s_num_valid = 1'b1;
    s_num_value = 10'd21;
    @(negedge clk);
    s_num_valid = 1'b0;
    s_num_value = 10'd0;
    s_char_ready = 1'b1;
    idx = 0; mism = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (s_char_valid) begin
        if (idx >= sp.len() || s_char_data != sp.getc(idx)) mism++;
        idx++;
        if (s_char_last) break;
      end
    end
    check("spaces_text", mism, 0);
    check("spaces_length", idx, 10);
    @(negedge clk);
    s_char_ready = 1'b0;
    check("spaces_letter_total", int'(s_letter_total), 9);

    // Reset four letters into "seventeen".
    send_num(17, w);
    collect("", 1'b0, 1'b0, 4, n, lat);
    @(negedge clk);
    char_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_char_valid", int'(char_valid), 0);
    check("midrst_letter_total", int'(letter_total), 0);
    check("midrst_char_last", int'(char_last), 0);
    check("midrst_num_ready", int'(num_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    send_num(7, w);
    collect("seven", 1'b1, 1'b0, 0, n, lat);
    @(negedge clk);
    check("post_rst_letter_total", int'(letter_total), 5);

    // Full sweep with random backpressure.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    letters_seen = 0;
    lasts_seen = 0;
    for (int v = 1; v <= 1000; v++) begin
      send_num(v, w);
      collect("", 1'b0, 1'b1, 0, n, lat);
    end
    @(negedge clk);
    check("sweep_letter_total", int'(letter_total), 21124);
    check("sweep_letters_seen", letters_seen, 21124);
    check("sweep_last_count", lasts_seen, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
